// File: rtl/bk_multiword_add_seq_pkg.sv
// Shared constants and types for the multi-word Brent-Kung adder sequencer.
// Build option: ADDSEQ_SUB_EN adds subtract mode (in_sub) and signed overflow (out_ovf).
package bk_seq_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/bk_multiword_add_seq_if.sv
// Request/result bundle for the adder sequencer; master = requester/consumer side, slave = sequencer.
// Build option: ADDSEQ_SUB_EN adds in_sub and out_ovf to the bundle.
interface bk_multiword_add_seq_if import bk_seq_pkg::*; #(
  parameter int WORDS = 4
) ();

  localparam int N = SLICE_W * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;
  logic         out_zero;
`ifdef ADDSEQ_SUB_EN
  logic         in_sub;
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_zero, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_zero, out_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_zero
  );
`endif

endinterface

// File: rtl/bk_multiword_add_seq_bk.sv
// 8-bit Brent-Kung parallel-prefix adder, purely combinational (a + b + cin).
// Up-sweep builds block generate/propagate pairs, down-sweep fills in the odd prefixes.
module Brent_kung_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic       g10, p10, g32, p32, g54, p54, g76, p76;
  logic       g30, p30, g74, p74, g70;
  logic       g20, g40, g50, p50, g60;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign g10 = g[1] | (p[1] & g[0]);
  assign p10 = p[1] & p[0];
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];
  assign g54 = g[5] | (p[5] & g[4]);
  assign p54 = p[5] & p[4];
  assign g76 = g[7] | (p[7] & g[6]);
  assign p76 = p[7] & p[6];

  assign g30 = g32 | (p32 & g10);
  assign p30 = p32 & p10;
  assign g74 = g76 | (p76 & g54);
  assign p74 = p76 & p54;
  assign g70 = g74 | (p74 & g30);

  // down-sweep: remaining prefixes from the already-built block terms
  assign g20 = g[2] | (p[2] & g10);
  assign g40 = g[4] | (p[4] & g30);
  assign g50 = g54 | (p54 & g30);
  assign p50 = p54 & p30;
  assign g60 = g[6] | (p[6] & g50);

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g10 | (p10 & cin);
  assign c[3] = g20 | (p[2] & p10 & cin);
  assign c[4] = g30 | (p30 & cin);
  assign c[5] = g40 | (p[4] & p30 & cin);
  assign c[6] = g50 | (p50 & cin);
  assign c[7] = g60 | (p[6] & p50 & cin);
  assign c[8] = g70 | (p74 & p30 & cin);

  assign sum  = p ^ c[7:0];
  assign cout = c[8];

endmodule

// File: rtl/bk_multiword_add_seq.sv
// Multi-precision adder: one shared 8-bit Brent-Kung slice, one byte per clk LSB first; result WORDS cycles after accept.
// Build option: ADDSEQ_SUB_EN enables A-B via in_sub and reports signed overflow on out_ovf.
module bk_multiword_add_seq import bk_seq_pkg::*; #(
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bk_multiword_add_seq_if.slave  bus,
  output logic                   busy
);

  localparam int N    = SLICE_W * WORDS;
  localparam int IDXW = $clog2(WORDS);

  seq_state_t           state_q;
  logic [N-1:0]         a_q;
  logic [N-1:0]         b_q;
  logic [N-1:0]         sum_q;
  logic                 carry_q;
  logic [IDXW-1:0]      idx_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 cout_q;
  logic                 zero_q;
  logic                 busy_q;

  logic [SLICE_W-1:0]   slice_a;
  logic [SLICE_W-1:0]   slice_b;
  logic [SLICE_W-1:0]   slice_sum;
  logic                 slice_cout;
  logic                 last_d;
  logic                 zero_d;

`ifdef ADDSEQ_SUB_EN
  logic                 sub_q;
  logic                 ovf_q;
  logic                 ovf_d;
`endif

  assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
`ifdef ADDSEQ_SUB_EN
  assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W] ^ {SLICE_W{sub_q}};
`else
  assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];
`endif

  Brent_kung_adder u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign last_d = (idx_q == IDXW'(WORDS - 1));
  // lower bytes are already final when the top byte is being produced
  assign zero_d = (slice_sum == '0) && (sum_q[N-SLICE_W-1:0] == '0);

`ifdef ADDSEQ_SUB_EN
  // carry into the MSB is recovered from the MSB sum bit
  assign ovf_d = (slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1] ^ slice_sum[SLICE_W-1]) ^ slice_cout;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ADDSEQ_SUB_EN
      sub_q       <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.in_a;
            b_q        <= bus.in_b;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
`ifdef ADDSEQ_SUB_EN
            sub_q      <= bus.in_sub;
            carry_q    <= bus.in_sub ? 1'b1 : bus.in_cin;
`else
            carry_q    <= bus.in_cin;
`endif
          end else begin
            in_ready_q <= 1'b1;
          end
        end

        RUN: begin
          sum_q[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
          carry_q <= slice_cout;
          if (last_d) begin
            cout_q      <= slice_cout;
            zero_q      <= zero_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef ADDSEQ_SUB_EN
            ovf_q       <= ovf_d;
`endif
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_zero  = zero_q;
  assign busy          = busy_q;
`ifdef ADDSEQ_SUB_EN
  assign bus.out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_bk_multiword_add_seq.sv
// Directed bench for bk_multiword_add_seq (WORDS=4); subtract vectors run when ADDSEQ_SUB_EN is defined.
module tb_bk_multiword_add_seq;

  localparam int WORDS = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  bk_multiword_add_seq_if #(.WORDS(WORDS)) bus ();

  bk_multiword_add_seq #(.WORDS(WORDS)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a request and returns at the negedge one cycle after the accept edge.
  task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    int n;
    @(negedge clk);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
`ifdef ADDSEQ_SUB_EN
    bus.in_sub   = sub;
`endif
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    // operands must be ignored after the accept edge
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
    bus.in_cin   = ~cin;
`ifdef ADDSEQ_SUB_EN
    bus.in_sub   = ~sub;
`endif
  endtask

  // Cycle 0 is the handshake cycle; lat is the cycle in which out_valid is first seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, input logic [31:0] exp_sum, input logic exp_cout,
                          input logic exp_zero, input logic exp_ovf, input int hold);
    int lat;
    drive_req(a, b, cin, sub);
    wait_done(lat);
    chk({tag, "_lat"}, 64'(lat), 64'd5);
    chk({tag, "_sum"}, 64'(bus.out_sum), 64'(exp_sum));
    chk({tag, "_cout"}, {63'd0, bus.out_cout}, {63'd0, exp_cout});
    chk({tag, "_zero"}, {63'd0, bus.out_zero}, {63'd0, exp_zero});
`ifdef ADDSEQ_SUB_EN
    if (sub) chk({tag, "_ovf"}, {63'd0, bus.out_ovf}, {63'd0, exp_ovf});
`endif
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_vld"}, {63'd0, bus.out_valid}, 64'd1);
      chk({tag, "_hold_sum"}, 64'(bus.out_sum), 64'(exp_sum));
      chk({tag, "_hold_rdy"}, {63'd0, bus.in_ready}, 64'd0);
    end
    take_result();
    chk({tag, "_vld_drop"}, {63'd0, bus.out_valid}, 64'd0);
  endtask

  logic [31:0] bb_a   [3] = '{32'h0000_0001, 32'h0000_00FF, 32'hAAAA_AAAA};
  logic [31:0] bb_b   [3] = '{32'h0000_0002, 32'h0000_0001, 32'h5555_5555};
  logic        bb_cin [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] bb_sum [3] = '{32'h0000_0003, 32'h0000_0101, 32'hFFFF_FFFF};

  initial begin
    int  cyc, k, r;
    int  acc_c [3];
    bit  adv, seen;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
`ifdef ADDSEQ_SUB_EN
    bus.in_sub    = 1'b0;
`endif

    #12;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_sum", 64'(bus.out_sum), 64'd0);
    chk("rst_cout", {63'd0, bus.out_cout}, 64'd0);
    chk("rst_zero", {63'd0, bus.out_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);

    op_check("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1);
    op_check("mixed", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0, 1);
    op_check("bp", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 10);

    // back-to-back: in_valid held high across three operations, consumer always ready
    cyc = 0; k = 0; r = 0; adv = 1'b0;
    @(negedge clk);
    bus.in_a      = bb_a[0];
    bus.in_b      = bb_b[0];
    bus.in_cin    = bb_cin[0];
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (r < 3 && cyc < 200) begin
      if (adv) begin
        adv = 1'b0;
        k++;
        if (k < 3) begin
          bus.in_a   = bb_a[k];
          bus.in_b   = bb_b[k];
          bus.in_cin = bb_cin[k];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        chk("b2b_sum", 64'(bus.out_sum), 64'(bb_sum[r]));
        chk("b2b_cout", {63'd0, bus.out_cout}, 64'd0);
        r++;
      end
      if (bus.in_valid && bus.in_ready && k < 3) begin
        chk("b2b_acc_idle", {63'd0, busy}, 64'd0);
        acc_c[k] = cyc;
        adv = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b_results", 64'(r), 64'd3);
    chk("b2b_accepts", 64'(k), 64'd3);
    chk("b2b_gap01", 64'(acc_c[1] - acc_c[0]), 64'd6);
    chk("b2b_gap12", 64'(acc_c[2] - acc_c[1]), 64'd6);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("b2b_no_dup", {63'd0, seen}, 64'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // reset while the slice is working on byte 2
    drive_req(32'h0102_0304, 32'h0506_0708, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_vld", {63'd0, bus.out_valid}, 64'd0);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_vld", {63'd0, seen}, 64'd0);
    op_check("after_rst", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1);

`ifdef ADDSEQ_SUB_EN
    op_check("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1);
    op_check("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
